toggle_channel_scheduler: RTL and testbench
===========================================

# toggle_channel_scheduler

Round-robin time-slot scheduler that shares a single LED/mux output among several toggle-generator channels. Each channel owns a count-and-toggle generator whose enable this block drives. Requesters (e.g. switches) raise i_Req bits. The block grants one channel at a time for a fixed dwell and steers the output mux to it. Between grants it forces a gap with all enables low, so the next granted generator starts from its reset state (output 0, fresh count).

## Interface
- NUM_CH, default 4: number of channels/requesters. Legal range 2..8.
- DWELL_CYCLES, default 1000: clock cycles a granted enable stays high for a full slot. Must be ≥ 1.
- GAP_CYCLES, default 2: cycles all enables are held low between slots. Must be ≥ 1.
- i_Clk  in  1  system clock; all state changes on its rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Req  in  NUM_CH  per-channel request level. Sampled synchronously; the block does no synchronisation of its own.
- o_Enable  out  NUM_CH  one-hot or all-zero enable to the channel generators.
- o_Sel  out  $clog2(NUM_CH)  mux select, index of the current or most recent grantee.
- o_Busy  out  1  high in ACTIVE and GAP.
- o_Slot_Done  out  1  one-cycle pulse when a slot completes its full dwell.

## Operation
- All outputs are registered.
- Reset values: o_Enable=0, o_Sel=0, o_Busy=0, o_Slot_Done=0, state=IDLE, dwell counter=0, round-robin pointer=NUM_CH-1 (so channel 0 has top priority first).
- Arbitration: search i_Req starting at pointer+1 and wrap modulo NUM_CH. The first set bit wins. On a win, the pointer is set to the winner, so the winner is lowest priority in the next search.
- States:
  - IDLE: if i_Req≠0, the next edge enters ACTIVE and sets o_Enable=1<<winner, o_Sel=winner, dwell counter=0. Otherwise remain in IDLE.
  - ACTIVE: the counter increments each cycle.
    - If i_Req[o_Sel]=0 (early drop), or the counter==DWELL_CYCLES-1 (full slot), the next edge enters GAP with o_Enable=0 and counter=0.
    - o_Slot_Done pulses in the first GAP cycle only for a full slot. There is no pulse on an early drop.
    - If both conditions hold in the same cycle, treat it as an early drop (no pulse).
  - GAP: o_Enable=0 and o_Sel holds its value. The counter counts to GAP_CYCLES-1. In the last GAP cycle, arbitrate on that cycle's i_Req: any request goes directly to ACTIVE (winner), none goes to IDLE.
- A lone persistent requester is re-granted after every gap. Each re-grant restarts its generator from 0.
- Changes to other i_Req bits during ACTIVE have no effect until the next arbitration.
- Counter width is $clog2(max(DWELL_CYCLES,GAP_CYCLES))+1 bits; it never wraps.
- Reset asserted mid-slot drops o_Enable to 0 immediately (asynchronously). After reset release, arbitration restarts at channel 0.

## Timing
- Request-to-enable latency from IDLE: 1 cycle. The edge that samples i_Req sets o_Enable.
- A full slot gives exactly DWELL_CYCLES cycles of o_Enable high.
- The gap gives exactly GAP_CYCLES cycles of o_Enable=0.
- A slot boundary spans DWELL_CYCLES+GAP_CYCLES cycles per grant.
- Early drop: o_Enable falls on the edge after the cycle in which i_Req[o_Sel] is seen low (1-cycle latency).
- o_Sel changes only on entry to ACTIVE, coincident with the enable rising. It never changes while an enable is high.
- o_Busy rises with the entry to ACTIVE and falls on the edge entering IDLE.
- o_Slot_Done is high for exactly one cycle, aligned with the first GAP cycle.

## Test plan
All scenarios use NUM_CH=4, DWELL_CYCLES=4, GAP_CYCLES=2.
1. Reset, then i_Req=0000 for 20 cycles → o_Enable=0000, o_Sel=0, o_Busy=0, no o_Slot_Done pulse.
2. i_Req=0100 held → o_Enable=0100 for 4 cycles, then 0000 for 2 cycles, repeating. o_Sel=2 throughout. o_Slot_Done pulses every 6 cycles.
3. i_Req=1111 held from reset → grant order 0,1,2,3,0. Each grant lasts 4 cycles, separated by 2 idle cycles.
4. Grant channel 1, drop i_Req[1] in the 2nd dwell cycle while i_Req[3]=1 → enable 0010 falls after 2 cycles with no o_Slot_Done. After 2 gap cycles o_Enable=1000 and o_Sel=3.
5. i_Req goes 0001→0000 during GAP → in the last gap cycle i_Req=0, so state returns to IDLE and o_Busy falls. A new request 1000 then grants channel 3 after 1 cycle.
6. Assert i_Rst mid-dwell with o_Enable=0010 → o_Enable=0000 immediately. After release with i_Req=0011, the first grant goes to channel 0.

Source files
------------

// File: rtl/toggle_channel_scheduler.sv
`default_nettype none
// ============================================================================
// toggle_channel_scheduler: round-robin time-slot grant of one toggle channel
// at a time, with a forced all-off gap between slots.        Revision: 1.0
// ============================================================================
module toggle_channel_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic [NUM_CH-1:0]         i_Req,
    output logic [NUM_CH-1:0]         o_Enable,
    output logic [$clog2(NUM_CH)-1:0] o_Sel,
    output logic                      o_Busy,
    output logic                      o_Slot_Done
);

    localparam int SEL_W   = $clog2(NUM_CH);
    localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [NUM_CH-1:0]   enable_q, enable_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                win_found;
    logic [SEL_W-1:0]    winner;

    // Search starts one past the last winner, so the last grantee is lowest priority.
    always_comb begin
        logic [SEL_W-1:0] idx;
        win_found = 1'b0;
        winner    = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = SEL_W'((int'(ptr_q) + i) % NUM_CH);
            if (!win_found && i_Req[idx]) begin
                win_found = 1'b1;
                winner    = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ptr_d    = ptr_q;
        enable_d = enable_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = ACTIVE;
                    enable_d = NUM_CH'(1) << winner;
                    sel_d    = winner;
                    ptr_d    = winner;
                    count_d  = '0;
                    busy_d   = 1'b1;
                end
            end

            ACTIVE: begin
                // An early drop wins over a simultaneous full slot: no pulse.
                if (!i_Req[sel_q]) begin
                    state_d  = GAP;
                    enable_d = '0;
                    count_d  = '0;
                end else if (count_q == DWELL_LAST) begin
                    state_d  = GAP;
                    enable_d = '0;
                    count_d  = '0;
                    done_d   = 1'b1;
                end else begin
                    count_d  = count_q + CW'(1);
                end
            end

            GAP: begin
                if (count_q == GAP_LAST) begin
                    count_d = '0;
                    if (win_found) begin
                        state_d  = ACTIVE;
                        enable_d = NUM_CH'(1) << winner;
                        sel_d    = winner;
                        ptr_d    = winner;
                    end else begin
                        state_d  = IDLE;
                        busy_d   = 1'b0;
                    end
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                enable_d = '0;
                count_d  = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            ptr_q    <= SEL_W'(NUM_CH - 1);
            enable_q <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ptr_q    <= ptr_d;
            enable_q <= enable_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_Enable    = enable_q;
    assign o_Sel       = sel_q;
    assign o_Busy      = busy_q;
    assign o_Slot_Done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_channel_scheduler.sv
`default_nettype none
// ============================================================================
// tb_toggle_channel_scheduler: directed scenarios plus random requests against
// a slot/gap countdown model of the scheduler.               Revision: 1.0
// ============================================================================
module tb_toggle_channel_scheduler;

    localparam int NUM_CH = 4;
    localparam int DWELL  = 4;
    localparam int GAP    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUM_CH-1:0] req = '0;
    logic [NUM_CH-1:0] enable;
    logic [1:0]        sel;
    logic              busy;
    logic              slot_done;

    int total = 0;
    int bad   = 0;

    toggle_channel_scheduler #(
        .NUM_CH      (NUM_CH),
        .DWELL_CYCLES(DWELL),
        .GAP_CYCLES  (GAP)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Req      (req),
        .o_Enable   (enable),
        .o_Sel      (sel),
        .o_Busy     (busy),
        .o_Slot_Done(slot_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0=idle 1=slot 2=gap, with remaining-cycle countdowns.
    int m_phase = 0;
    int m_owner = 0;
    int m_left  = 0;
    int m_last  = NUM_CH - 1;
    int m_done  = 0;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_left = 0; m_last = NUM_CH - 1; m_done = 0;
    endtask

    task automatic model_grant_or_idle(input logic [NUM_CH-1:0] r);
        int pick;
        pick = -1;
        for (int k = 1; k <= NUM_CH; k++)
            if (pick < 0 && r[(m_last + k) % NUM_CH]) pick = (m_last + k) % NUM_CH;
        if (pick >= 0) begin
            m_phase = 1; m_owner = pick; m_last = pick; m_left = DWELL;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic model_step(input logic [NUM_CH-1:0] r);
        m_done = 0;
        if (m_phase == 0) begin
            model_grant_or_idle(r);
        end else if (m_phase == 1) begin
            m_left--;
            if (!r[m_owner]) begin
                m_phase = 2; m_left = GAP;
            end else if (m_left == 0) begin
                m_phase = 2; m_left = GAP; m_done = 1;
            end
        end else begin
            m_left--;
            if (m_left == 0) model_grant_or_idle(r);
        end
    endtask

    // Compare process: model advances on every edge, outputs checked 1 time unit later.
    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step(req);
        #1;
        chk("enable", int'(enable), (m_phase == 1) ? (1 << m_owner) : 0);
        chk("sel",    int'(sel),    m_owner);
        chk("busy",   int'(busy),   (m_phase != 0) ? 1 : 0);
        chk("done",   int'(slot_done), m_done);
    end

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        edges(2);
        rst = 1'b0;
    endtask

    int done_cnt;
    int prev_en;
    int order[$];
    int expect_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        // 1: idle with no requests
        rst = 1'b1;
        req = '0;
        edges(2);
        rst = 1'b0;
        chk("rst_enable", int'(enable), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            edges(1);
            if (slot_done) done_cnt++;
            if (enable != 0 || busy) done_cnt += 100;
        end
        chk("idle_activity", done_cnt, 0);

        // 2: lone persistent requester on channel 2
        do_reset();
        req = 4'b0100;
        edges(1);
        chk("s2_first_enable", int'(enable), 4);
        chk("s2_first_sel", int'(sel), 2);
        done_cnt = 0;
        if (slot_done) done_cnt++;
        for (int c = 2; c <= 24; c++) begin
            edges(1);
            if (slot_done) done_cnt++;
            if (c == 4) chk("s2_last_dwell", int'(enable), 4);
            if (c == 5) chk("s2_gap1", int'(enable), 0);
            if (c == 6) chk("s2_gap2", int'(enable), 0);
            if (c == 7) chk("s2_regrant", int'(enable), 4);
        end
        chk("s2_done_pulses", done_cnt, 4);

        // 3: all requesting, round-robin order
        do_reset();
        req = 4'b1111;
        prev_en = 0;
        order.delete();
        for (int c = 0; c < 26; c++) begin
            edges(1);
            if (enable != 0 && prev_en == 0) order.push_back(int'(sel));
            prev_en = int'(enable);
        end
        chk("s3_grant_count", order.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < order.size()) chk("s3_grant_order", order[k], expect_order[k]);

        // 4: early drop of channel 1, channel 3 waiting
        do_reset();
        req = 4'b1010;
        edges(1);
        chk("s4_grant1", int'(enable), 2);
        done_cnt = 0;
        edges(1);
        req = 4'b1000;
        edges(1);
        chk("s4_drop", int'(enable), 0);
        if (slot_done) done_cnt++;
        edges(1);
        if (slot_done) done_cnt++;
        edges(1);
        chk("s4_no_done", done_cnt, 0);
        chk("s4_grant3_en", int'(enable), 8);
        chk("s4_grant3_sel", int'(sel), 3);

        // 5: request vanishes during gap, then a fresh request
        do_reset();
        req = 4'b0001;
        edges(5);
        chk("s5_in_gap", int'(slot_done), 1);
        req = 4'b0000;
        edges(2);
        chk("s5_idle_busy", int'(busy), 0);
        req = 4'b1000;
        edges(1);
        chk("s5_grant3_en", int'(enable), 8);
        chk("s5_grant3_sel", int'(sel), 3);

        // 6: asynchronous reset mid-dwell
        do_reset();
        req = 4'b0010;
        edges(2);
        chk("s6_pre_rst", int'(enable), 2);
        rst = 1'b1;
        #1;
        chk("s6_async_drop", int'(enable), 0);
        edges(1);
        rst = 1'b0;
        req = 4'b0011;
        edges(1);
        chk("s6_after_rst", int'(enable), 1);

        // Random requests with occasional mid-cycle resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                edges(1);
                rst = 1'b0;
            end else begin
                edges(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
